// File: rtl/alu_share_controller_pkg.sv
// Shared definitions for the ALU sharing controller: RV32I funct codes,
// controller FSM encoding and requester-count constants.
package alu_share_controller_pkg;

  localparam int NUM_REQ = 2;
  localparam int CNT_W   = 4;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } state_e;

  function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_share_controller_arb.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to
// the requester that did not win last time.
module alu_share_controller_arb (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    unique case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_controller.sv
// Time-shares one ALU between two requesters: arbitrate, latch operands,
// pulse the ALU enable, wait out its latency and hand the result back.
module alu_share_controller
  import alu_share_controller_pkg::*;
#(
  parameter int unsigned ALU_LATENCY = 1,
  parameter int unsigned XLEN        = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [2:0]      req_funct3_0,
  input  logic [2:0]      req_funct3_1,
  input  logic [6:0]      req_funct7_0,
  input  logic [6:0]      req_funct7_1,
  input  logic [XLEN-1:0] req_rs1_0,
  input  logic [XLEN-1:0] req_rs1_1,
  input  logic [XLEN-1:0] req_rs2_0,
  input  logic [XLEN-1:0] req_rs2_1,
  output logic [1:0]      resp_valid,
  input  logic [1:0]      resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            alu_enable,
  output logic [2:0]      alu_funct3,
  output logic [6:0]      alu_funct7,
  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  input  logic [XLEN-1:0] alu_result,
  output logic            busy
);

  if (ALU_LATENCY < 1 || ALU_LATENCY > 15) begin : g_bad_latency
    $error("alu_share_controller: ALU_LATENCY must be within 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(ALU_LATENCY - 1);

  state_e            state_q;
  logic              grant_id_q;
  logic              last_grant_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        resp_valid_q;
  logic [XLEN-1:0]   resp_data_q;
  logic              alu_en_q;
  logic [2:0]        alu_f3_q;
  logic [6:0]        alu_f7_q;
  logic [XLEN-1:0]   alu_rs1_q;
  logic [XLEN-1:0]   alu_rs2_q;

  logic [1:0]        grant;
  logic              win_id;
  logic [2:0]        win_f3;
  logic [6:0]        win_f7;
  logic [XLEN-1:0]   win_rs1;
  logic [XLEN-1:0]   win_rs2;

  alu_share_controller_arb u_arb (
    .valid_i      (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  // Winner's request fields, selected from the one-hot grant.
  always_comb begin
    win_id  = grant[1];
    win_f3  = win_id ? req_funct3_1 : req_funct3_0;
    win_f7  = win_id ? req_funct7_1 : req_funct7_0;
    win_rs1 = win_id ? req_rs1_1    : req_rs1_0;
    win_rs2 = win_id ? req_rs2_1    : req_rs2_0;
  end

  assign req_ready = (state_q == ST_IDLE) ? grant : 2'b00;
  assign busy      = (state_q != ST_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      resp_valid_q <= 2'b00;
      resp_data_q  <= '0;
      alu_en_q     <= 1'b0;
      alu_f3_q     <= '0;
      alu_f7_q     <= '0;
      alu_rs1_q    <= '0;
      alu_rs2_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Enable is raised here so it is high for exactly the ISSUE cycle.
          if (|req_valid) begin
            alu_f3_q     <= win_f3;
            alu_f7_q     <= win_f7;
            alu_rs1_q    <= win_rs1;
            alu_rs2_q    <= win_rs2;
            grant_id_q   <= win_id;
            last_grant_q <= win_id;
            alu_en_q     <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          alu_en_q <= 1'b0;
          cnt_q    <= CNT_RELOAD;
          state_q  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            resp_data_q  <= alu_result;
            resp_valid_q <= req_onehot(grant_id_q);
            state_q      <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          if (resp_ready[grant_id_q]) begin
            resp_valid_q <= 2'b00;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign alu_enable = alu_en_q;
  assign alu_funct3 = alu_f3_q;
  assign alu_funct7 = alu_f7_q;
  assign alu_rs1    = alu_rs1_q;
  assign alu_rs2    = alu_rs2_q;

endmodule

// File: tb/tb_alu_share_controller.sv
// Bench for alu_share_controller: a registered ALU model with fixed latency,
// directed scenarios followed by randomized traffic against a reference model.
module tb_alu_share_controller;
  import alu_share_controller_pkg::*;

  localparam int LAT = 3;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [2:0]  req_funct3_0, req_funct3_1;
  logic [6:0]  req_funct7_0, req_funct7_1;
  logic [31:0] req_rs1_0, req_rs1_1, req_rs2_0, req_rs2_1;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_data;
  logic        alu_enable;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic [31:0] alu_rs1, alu_rs2, alu_result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [2:0]  o_f3 [2];
  logic [6:0]  o_f7 [2];
  logic [31:0] o_a  [2];
  logic [31:0] o_b  [2];
  logic [31:0] o_e  [2];
  int          tb_last;
  int          cur_k;

  alu_share_controller #(.ALU_LATENCY(LAT), .XLEN(32)) dut (
    .clock        (clk),
    .reset_n      (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3_0 (req_funct3_0),
    .req_funct3_1 (req_funct3_1),
    .req_funct7_0 (req_funct7_0),
    .req_funct7_1 (req_funct7_1),
    .req_rs1_0    (req_rs1_0),
    .req_rs1_1    (req_rs1_1),
    .req_rs2_0    (req_rs2_0),
    .req_rs2_1    (req_rs2_1),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .alu_enable   (alu_enable),
    .alu_funct3   (alu_funct3),
    .alu_funct7   (alu_funct7),
    .alu_rs1      (alu_rs1),
    .alu_rs2      (alu_rs2),
    .alu_result   (alu_result),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [2:0] f3, input logic [6:0] f7,
                                         input logic [31:0] a, input logic [31:0] b);
    case (f3)
      F3_ADD_SUB: return (f7 == F7_ALT) ? a - b : a + b;
      F3_SLL:     return a << b[4:0];
      F3_SLT:     return {31'd0, $signed(a) < $signed(b)};
      F3_SLTU:    return {31'd0, a < b};
      F3_XOR:     return a ^ b;
      F3_SRL_SRA: return (f7 == F7_ALT) ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      F3_OR:      return a | b;
      F3_AND:     return a & b;
      default:    return 32'hDEADBEEF;
    endcase
  endfunction

  // ALU model: result is only valid in the single cycle LAT edges after enable.
  logic [31:0]    pd [LAT];
  logic [LAT-1:0] pv;
  always @(posedge clk) begin
    if (!rst_n) pv <= '0;
    else        pv <= {pv[LAT-2:0], alu_enable};
    pd[0] <= alu_fn(alu_funct3, alu_funct7, alu_rs1, alu_rs2);
    for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
  end
  assign alu_result = pv[LAT-1] ? pd[LAT-1] : 32'hDEADBEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int k, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    o_f3[k] = f3; o_f7[k] = f7; o_a[k] = a; o_b[k] = b; o_e[k] = e;
  endtask

  task automatic rand_op(input int k);
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b;
    f3 = 3'($urandom);
    if ($urandom_range(0, 3) == 0) f7 = 7'($urandom);
    else                           f7 = $urandom_range(0, 1) ? F7_ALT : F7_BASE;
    a = $urandom;
    b = $urandom;
    set_op(k, f3, f7, a, b, alu_fn(f3, f7, a, b));
  endtask

  task automatic drive(input int k);
    if (k == 0) begin
      req_funct3_0 = o_f3[0]; req_funct7_0 = o_f7[0]; req_rs1_0 = o_a[0]; req_rs2_0 = o_b[0];
    end else begin
      req_funct3_1 = o_f3[1]; req_funct7_1 = o_f7[1]; req_rs1_1 = o_a[1]; req_rs2_1 = o_b[1];
    end
    req_valid[k] = 1'b1;
  endtask

  // Request from k until accepted, then follow the op until its result appears.
  task automatic issue(input int k);
    int n;
    logic [1:0] oh;
    oh = 2'b01 << k;
    drive(k);
    #1;
    n = 0;
    while (req_ready === 2'b00 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready_grant", req_ready, oh);
    @(posedge clk); #1;
    tb_last = k;
    req_valid[k] = 1'b0;
    if (k == 0) begin
      req_rs1_0 = $urandom; req_rs2_0 = $urandom; req_funct3_0 = 3'($urandom);
    end else begin
      req_rs1_1 = $urandom; req_rs2_1 = $urandom; req_funct3_1 = 3'($urandom);
    end
    chk("alu_enable_issue", alu_enable, 1);
    chk("alu_funct3", alu_funct3, o_f3[k]);
    chk("alu_funct7", alu_funct7, o_f7[k]);
    chk("alu_rs1", alu_rs1, o_a[k]);
    chk("alu_rs2", alu_rs2, o_b[k]);
    chk("busy_issue", busy, 1);
    chk("req_ready_busy", req_ready, 0);
    n = 0;
    while (resp_valid === 2'b00 && n < 40) begin
      @(posedge clk); #1; n++;
      chk("alu_enable_low", alu_enable, 0);
      chk("alu_rs1_hold", alu_rs1, o_a[k]);
    end
    chk("resp_latency", 32'(n), 32'(LAT + 1));
    chk("resp_valid", resp_valid, oh);
    chk("resp_data", resp_data, o_e[k]);
    cur_k = k;
  endtask

  // Stall in RESPOND, optionally raise the next request alongside resp_ready.
  task automatic drain(input int stall, input bit nxt, input int nk);
    logic [1:0] oh;
    oh = 2'b01 << cur_k;
    for (int s = 0; s < stall; s++) begin
      resp_ready = 2'b01 << (1 - cur_k);
      @(posedge clk); #1;
      chk("stall_resp_valid", resp_valid, oh);
      chk("stall_resp_data", resp_data, o_e[cur_k]);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_alu_enable", alu_enable, 0);
    end
    resp_ready = oh | (2'($urandom) & ~oh);
    if (nxt) begin
      drive(nk);
      #1;
      chk("respond_req_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    resp_ready = 2'b00;
    chk("release_resp_valid", resp_valid, 0);
    chk("release_busy", busy, 0);
    if (nxt) chk("next_req_ready", req_ready, 2'b01 << nk);
  endtask

  initial begin
    int mask, g;
    rst_n = 1'b0;
    req_valid = 2'b00;
    resp_ready = 2'b00;
    req_funct3_0 = '0; req_funct3_1 = '0; req_funct7_0 = '0; req_funct7_1 = '0;
    req_rs1_0 = '0; req_rs1_1 = '0; req_rs2_0 = '0; req_rs2_1 = '0;
    tb_last = 1;
    cur_k = 0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_alu_enable", alu_enable, 0);
    chk("rst_alu_rs1", alu_rs1, 0);
    chk("rst_alu_rs2", alu_rs2, 0);
    chk("rst_alu_funct", {22'd0, alu_funct7, alu_funct3}, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Contention straight after reset: req0 first, then req1.
    set_op(0, F3_ADD_SUB, F7_ALT, 32'd10, 32'd3, 32'd7);
    set_op(1, F3_XOR, F7_BASE, 32'h0000F0F0, 32'h00000FF0, 32'h0000FF00);
    drive(1);
    issue(0); drain(0, 0, 0);
    issue(1); drain(0, 0, 0);

    // Next tie returns to req0; plain ADD with a five-cycle backpressure stall.
    set_op(0, F3_ADD_SUB, F7_BASE, 32'd5, 32'd7, 32'd12);
    set_op(1, F3_OR, F7_BASE, 32'h000000F0, 32'h00000F00, 32'h00000FF0);
    drive(1);
    issue(0); drain(5, 0, 0);
    issue(1); drain(0, 0, 0);

    // Asynchronous reset while the ALU op is in flight.
    set_op(0, F3_SLT, F7_BASE, 32'hFFFFFFFF, 32'd1, 32'd1);
    drive(0);
    #1;
    chk("midop_req_ready", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midop_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midop_rst_resp_valid", resp_valid, 0);
    chk("midop_rst_resp_data", resp_data, 0);
    chk("midop_rst_alu_rs1", alu_rs1, 0);
    chk("midop_rst_alu_enable", alu_enable, 0);
    chk("midop_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("midop_no_resp", resp_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    tb_last = 1;
    set_op(0, F3_ADD_SUB, F7_BASE, 32'd1, 32'd1, 32'd2);
    set_op(1, F3_SLL, F7_BASE, 32'd1, 32'd4, 32'd16);
    drive(1);
    issue(0); drain(0, 0, 0);
    issue(1); drain(1, 0, 0);

    // resp_ready and a new request in the same RESPOND cycle.
    set_op(0, F3_AND, F7_BASE, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00);
    set_op(1, F3_SRL_SRA, F7_ALT, 32'h80000000, 32'd4, 32'hF8000000);
    issue(0); drain(1, 1, 1);
    issue(1); drain(0, 0, 0);

    // Randomized traffic with reference-model arbitration.
    for (int it = 0; it < 25; it++) begin
      mask = $urandom_range(1, 3);
      rand_op(0);
      rand_op(1);
      if (mask == 3) begin
        g = (tb_last == 0) ? 1 : 0;
        drive(1 - g);
        issue(g);     drain($urandom_range(0, 3), 0, 0);
        issue(1 - g); drain($urandom_range(0, 3), 0, 0);
      end else begin
        issue(mask - 1);
        drain($urandom_range(0, 3), 0, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
